// File: rtl/stall_ctrl_pkg.sv
// Shared widths, latency defaults and the Tuse/Tnew RAW-hazard test for the stall controller.
package stall_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TUSE_W = 2;

    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam int unsigned CNT_W_DEF    = 4;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [TUSE_W-1:0] tcyc_t;

    // A producer blocks the consumer when its result arrives later than it is needed.
    function automatic logic raw_hit(reg_idx_t src, tcyc_t tuse, reg_idx_t wa, tcyc_t tnew);
        return (tuse < tnew) && (src == wa) && (wa != '0);
    endfunction

endpackage

// File: rtl/stall_ctrl_hazard_cmp.sv
// Tuse/Tnew hazard compare for one D-stage source register against the E and M producers.
module stall_ctrl_hazard_cmp
    import stall_ctrl_pkg::*;
(
    input  logic [REG_W-1:0]  src,
    input  logic [TUSE_W-1:0] tuse,
    input  logic [REG_W-1:0]  e_wa,
    input  logic [TUSE_W-1:0] e_tnew,
    input  logic [REG_W-1:0]  m_wa,
    input  logic [TUSE_W-1:0] m_tnew,
    output logic              stall
);

    logic src_read;

    // Redundant with the compare (Tnew never exceeds 2) but makes the "not read" case explicit.
    assign src_read = (tuse != TUSE_NONE);

    assign stall = src_read &
                   (raw_hit(src, tuse, e_wa, e_tnew) | raw_hit(src, tuse, m_wa, m_tnew));

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard scheduler: register-hazard and mult/div busy stalls, plus a stall counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic [TUSE_W-1:0] d_tuse_rs,
    input  logic [TUSE_W-1:0] d_tuse_rt,
    input  logic              d_md,
    input  logic [REG_W-1:0]  e_wa,
    input  logic [TUSE_W-1:0] e_tnew,
    input  logic [REG_W-1:0]  m_wa,
    input  logic [TUSE_W-1:0] m_tnew,
    input  logic              e_md_start,
    input  logic              e_md_div,
    output logic              pc_en,
    output logic              d_en,
    output logic              e_flush,
    output logic              md_busy,
    output logic [31:0]       stall_cnt
);

    logic             rs_stall;
    logic             rt_stall;
    logic             md_stall;
    logic             stall;
    logic             cnt_busy;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      stall_cnt_q;

    stall_ctrl_hazard_cmp u_rs_cmp (
        .src    (d_rs),
        .tuse   (d_tuse_rs),
        .e_wa   (e_wa),
        .e_tnew (e_tnew),
        .m_wa   (m_wa),
        .m_tnew (m_tnew),
        .stall  (rs_stall)
    );

    stall_ctrl_hazard_cmp u_rt_cmp (
        .src    (d_rt),
        .tuse   (d_tuse_rt),
        .e_wa   (e_wa),
        .e_tnew (e_tnew),
        .m_wa   (m_wa),
        .m_tnew (m_tnew),
        .stall  (rt_stall)
    );

    assign cnt_busy = (cnt_q != '0);
    assign md_stall = d_md & (e_md_start | cnt_busy);
    assign stall    = rs_stall | rt_stall | md_stall;

    // Outputs fall back to free-running values while reset is held.
    assign pc_en     = ~stall | ~reset;
    assign d_en      = ~stall | ~reset;
    assign e_flush   = stall & reset;
    assign md_busy   = reset & (cnt_busy | e_md_start);
    assign stall_cnt = stall_cnt_q;

    // A new op in E always reloads, so the most recent mult/div sets the remaining latency.
    always_comb begin
        cnt_d = cnt_q;
        if (e_md_start) begin
            cnt_d = e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt_busy) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl.
module tb_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic        d_md;
    logic [4:0]  e_wa;
    logic [1:0]  e_tnew;
    logic [4:0]  m_wa;
    logic [1:0]  m_tnew;
    logic        e_md_start;
    logic        e_md_div;
    logic        pc_en;
    logic        d_en;
    logic        e_flush;
    logic        md_busy;
    logic [31:0] stall_cnt;

    int n_pass;
    int n_total;

    stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_md       (d_md),
        .e_wa       (e_wa),
        .e_tnew     (e_tnew),
        .m_wa       (m_wa),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .pc_en      (pc_en),
        .d_en       (d_en),
        .e_flush    (e_flush),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_md = 1'b0;
        e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
        e_md_start = 1'b0; e_md_div = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            e_md_start = i[0];
            e_md_div   = ~i[0];
            d_md       = 1'b1;
            #2;
            n_total++;
            if ({pc_en, d_en, e_flush, md_busy} !== 4'b1100 || stall_cnt !== 32'd0)
                $display("FAIL reset_outputs[%0d]: pc_en/d_en/e_flush/md_busy=%b cnt=%0d, want 1100 cnt=0",
                         i, {pc_en, d_en, e_flush, md_busy}, stall_cnt);
            else n_pass++;
        end
        idle();
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #2;
            n_total++;
            if (md_busy !== 1'b0 || stall_cnt !== 32'd0)
                $display("FAIL post_reset[%0d]: md_busy=%b cnt=%0d, want 0 0", i, md_busy, stall_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        tick();
        e_wa = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd0;
        #2;
        n_total++;
        if ({pc_en, d_en, e_flush} !== 3'b001)
            $display("FAIL lw_in_e: pc_en/d_en/e_flush=%b, want 001", {pc_en, d_en, e_flush});
        else n_pass++;
        tick();
        e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd1; m_tnew = 2'd1;
        #2;
        n_total++;
        if (e_flush !== 1'b1) $display("FAIL lw_in_m: e_flush=%b, want 1", e_flush);
        else n_pass++;
        tick();
        m_wa = 5'd0; m_tnew = 2'd0;
        #2;
        n_total++;
        if (e_flush !== 1'b0 || pc_en !== 1'b1 || stall_cnt !== 32'd2)
            $display("FAIL lw_release: e_flush=%b pc_en=%b cnt=%0d, want 0 1 2",
                     e_flush, pc_en, stall_cnt);
        else n_pass++;
        idle();
    endtask

    task automatic test_reg_cases();
        tick();
        e_wa = 5'd0; e_tnew = 2'd2; d_rs = 5'd0; d_tuse_rs = 2'd0;
        #1;
        n_total++;
        if (e_flush !== 1'b0) $display("FAIL zero_reg: e_flush=%b, want 0", e_flush);
        else n_pass++;
        idle();
        e_wa = 5'd3; e_tnew = 2'd1; d_rt = 5'd3; d_tuse_rt = 2'd1;
        #1;
        n_total++;
        if (e_flush !== 1'b0) $display("FAIL rt_tuse_eq_tnew: e_flush=%b, want 0", e_flush);
        else n_pass++;
        d_tuse_rt = 2'd0;
        #1;
        n_total++;
        if (e_flush !== 1'b1) $display("FAIL rt_tuse_lt_tnew: e_flush=%b, want 1", e_flush);
        else n_pass++;
        d_tuse_rt = 2'd3; e_tnew = 2'd2;
        #1;
        n_total++;
        if (e_flush !== 1'b0) $display("FAIL rt_not_read: e_flush=%b, want 0", e_flush);
        else n_pass++;
        e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd3; m_tnew = 2'd2; d_tuse_rt = 2'd1;
        #1;
        n_total++;
        if (e_flush !== 1'b1) $display("FAIL rt_m_stage: e_flush=%b, want 1", e_flush);
        else n_pass++;
        idle();
        tick();
        n_total++;
        if (stall_cnt !== 32'd2) $display("FAIL probe_cnt: cnt=%0d, want 2", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_mult_stall();
        tick();
        e_md_start = 1'b1; e_md_div = 1'b0; d_md = 1'b1;
        #2;
        n_total++;
        if (e_flush !== 1'b1 || md_busy !== 1'b1)
            $display("FAIL mult_k: e_flush=%b md_busy=%b, want 1 1", e_flush, md_busy);
        else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            e_md_start = 1'b0;
            #2;
            n_total++;
            if (e_flush !== 1'b1 || md_busy !== 1'b1)
                $display("FAIL mult_k+%0d: e_flush=%b md_busy=%b, want 1 1", i, e_flush, md_busy);
            else n_pass++;
        end
        tick();
        #2;
        n_total++;
        if (e_flush !== 1'b0 || md_busy !== 1'b0 || stall_cnt !== 32'd8)
            $display("FAIL mult_release: e_flush=%b md_busy=%b cnt=%0d, want 0 0 8",
                     e_flush, md_busy, stall_cnt);
        else n_pass++;
        idle();
    endtask

    task automatic test_md_reload();
        tick();
        e_md_start = 1'b1; e_md_div = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            e_md_start = (i == 8);
            e_md_div   = 1'b0;
            #2;
            n_total++;
            if (md_busy !== 1'b1) $display("FAIL reload_busy[%0d]: md_busy=%b, want 1", i, md_busy);
            else n_pass++;
        end
        tick();
        #2;
        n_total++;
        if (md_busy !== 1'b0 || stall_cnt !== 32'd8)
            $display("FAIL reload_done: md_busy=%b cnt=%0d, want 0 8", md_busy, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_and_sat();
        tick();
        e_md_start = 1'b1; e_md_div = 1'b1;
        tick();
        e_md_start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        n_total++;
        if (md_busy !== 1'b1) $display("FAIL div_cnt7_busy: md_busy=%b, want 1", md_busy);
        else n_pass++;
        reset = 1'b0;
        d_md  = 1'b1;
        #1;
        n_total++;
        if ({pc_en, e_flush, md_busy} !== 3'b100 || stall_cnt !== 32'd0)
            $display("FAIL async_reset: pc_en/e_flush/md_busy=%b cnt=%0d, want 100 0",
                     {pc_en, e_flush, md_busy}, stall_cnt);
        else n_pass++;
        tick();
        #2;
        idle();
        reset = 1'b1;
        tick();
        #2;
        n_total++;
        if (md_busy !== 1'b0 || stall_cnt !== 32'd0)
            $display("FAIL reset_release: md_busy=%b cnt=%0d, want 0 0", md_busy, stall_cnt);
        else n_pass++;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        n_total++;
        if (stall_cnt !== 32'hFFFF_FFFE)
            $display("FAIL sat_preload: cnt=%h, want fffffffe", stall_cnt);
        else n_pass++;
        d_md = 1'b1; e_md_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (stall_cnt !== 32'hFFFF_FFFF || e_flush !== 1'b1)
                $display("FAIL sat[%0d]: cnt=%h e_flush=%b, want ffffffff 1", i, stall_cnt, e_flush);
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_load_use();
        test_reg_cases();
        test_mult_stall();
        test_md_reload();
        test_reset_mid_and_sat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
